exer_sprite_line_render: RTL and testbench

//  Per-scanline sprite renderer. It scans the 128-byte sprite attribute RAM
//  (32 sprites x 4 bytes) and fetches 16-px 2bpp rows from the gfx ROM.
//  It writes the visible pixels into the ping-pong 512x4 sprite line buffer
//  (m2511_ram_4 pair), one line ahead of display.
//  It sits between the sprite RAM (read side) and the line buffers (write side).

---
 rtl/exer_spr_pkg.sv | 26 ++
 rtl/exer_spr_row_shift.sv | 28 ++
 rtl/exer_sprite_line_render.sv | 186 ++++++++++++++++++
 tb/tb_exer_sprite_line_render.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exer_spr_pkg.sv
// Shared types and constants for the per-scanline sprite renderer.
package exer_spr_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_GREQ  = 3'd4,
        S_GWAIT = 3'd5,
        S_DRAW  = 3'd6,
        S_NEXT  = 3'd7
    } spr_state_e;

    localparam logic [1:0] BYTE_Y    = 2'd0;
    localparam logic [1:0] BYTE_CODE = 2'd1;
    localparam logic [1:0] BYTE_ATTR = 2'd2;
    localparam logic [1:0] BYTE_X    = 2'd3;

    localparam int ATTR_COLOR_LSB = 0;
    localparam int ATTR_HFLIP     = 6;
    localparam int ATTR_VFLIP     = 7;

    localparam logic [1:0] PEN_TRANSPARENT = 2'b00;

endpackage

// File: rtl/exer_spr_row_shift.sv
// Holds one fetched 16-pixel 2bpp gfx row and selects the pixel for the
// current draw column, mirrored when the sprite is horizontally flipped.
module exer_spr_row_shift (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        hflip_i,
    input  logic [3:0]  col_i,
    output logic [1:0]  pix_o
);

    logic [31:0] row_q;
    logic [3:0]  col_sel_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
        end else if (load_i) begin
            row_q <= data_i;
        end
    end

    // 15-i is just the bitwise complement of a 4-bit column
    assign col_sel_d = hflip_i ? ~col_i : col_i;
    assign pix_o     = row_q[{col_sel_d, 1'b0} +: 2];

endmodule

// File: rtl/exer_sprite_line_render.sv
// Scans the sprite attribute RAM from the highest index down, fetches each
// visible sprite's gfx row and writes its opaque pixels into the line buffer.
module exer_sprite_line_render
    import exer_spr_pkg::*;
#(
    parameter int NUM_SPR = 32,
    parameter int SPR_H   = 16,
    parameter int LB_AW   = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             line_start,
    input  logic [7:0]       target_line,
    output logic [6:0]       spr_addr,
    input  logic [7:0]       spr_data,
    output logic             gfx_req,
    output logic [11:0]      gfx_addr,
    input  logic             gfx_ack,
    input  logic [31:0]      gfx_data,
    output logic             lb_bank,
    output logic [LB_AW-1:0] lb_addr,
    output logic [3:0]       lb_data,
    output logic             lb_we_n,
    output logic             busy,
    output logic             overrun,
    output logic [2:0]       dbg_state
);

    localparam int         IW      = $clog2(NUM_SPR);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_SPR - 1);

    spr_state_e       state_q;
    logic [IW-1:0]    idx_q;
    logic [1:0]       byte_q;
    logic [7:0]       tl_q, y_q, code_q, x_q;
    logic [1:0]       color_q;
    logic             hflip_q, vflip_q;
    logic [3:0]       col_q;
    logic [6:0]       spr_addr_q;
    logic             gfx_req_q;
    logic [11:0]      gfx_addr_q;
    logic             lb_bank_q, lb_we_n_q, busy_q, overrun_q;
    logic [LB_AW-1:0] lb_addr_q;
    logic [3:0]       lb_data_q;

    logic [7:0]    dy_d;
    logic [3:0]    row_d;
    logic [1:0]    byte_inc_d;
    logic [IW-1:0] idx_dec_d;
    logic [1:0]    pix_d;
    logic          load_d;

    assign dy_d       = tl_q - y_q;
    assign row_d      = vflip_q ? ~dy_d[3:0] : dy_d[3:0];
    assign byte_inc_d = byte_q + 2'd1;
    assign idx_dec_d  = idx_q - 1'b1;
    assign load_d     = (state_q == S_GWAIT) && gfx_ack && !line_start;

    exer_spr_row_shift u_row_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (load_d),
        .data_i  (gfx_data),
        .hflip_i (hflip_q),
        .col_i   (col_q),
        .pix_o   (pix_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            byte_q     <= BYTE_Y;
            tl_q       <= '0;
            y_q        <= '0;
            code_q     <= '0;
            x_q        <= '0;
            color_q    <= '0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            col_q      <= '0;
            spr_addr_q <= '0;
            gfx_req_q  <= 1'b0;
            gfx_addr_q <= '0;
            lb_bank_q  <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
            lb_we_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            lb_we_n_q <= 1'b1;
            if (line_start) begin
                // A new line always wins; an unfinished scan is abandoned.
                overrun_q  <= busy_q;
                lb_bank_q  <= ~lb_bank_q;
                tl_q       <= target_line;
                idx_q      <= IDX_MAX;
                byte_q     <= BYTE_Y;
                spr_addr_q <= {IDX_MAX, BYTE_Y};
                gfx_req_q  <= 1'b0;
                busy_q     <= 1'b1;
                state_q    <= S_ADDR;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_IDLE;
                    S_ADDR: state_q <= S_READ;
                    S_READ: begin
                        case (byte_q)
                            BYTE_Y:    y_q    <= spr_data;
                            BYTE_CODE: code_q <= spr_data;
                            BYTE_ATTR: begin
                                color_q <= spr_data[ATTR_COLOR_LSB +: 2];
                                hflip_q <= spr_data[ATTR_HFLIP];
                                vflip_q <= spr_data[ATTR_VFLIP];
                            end
                            default:   x_q    <= spr_data;
                        endcase
                        if (byte_q != BYTE_X) begin
                            byte_q     <= byte_inc_d;
                            spr_addr_q <= {idx_q, byte_inc_d};
                            state_q    <= S_ADDR;
                        end else begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (y_q == 8'd0 || dy_d >= 8'(SPR_H)) begin
                            state_q <= S_NEXT;
                        end else begin
                            gfx_addr_q <= {code_q, row_d};
                            state_q    <= S_GREQ;
                        end
                    end
                    S_GREQ: begin
                        gfx_req_q <= 1'b1;
                        state_q   <= S_GWAIT;
                    end
                    S_GWAIT: begin
                        if (gfx_ack) begin
                            gfx_req_q <= 1'b0;
                            col_q     <= '0;
                            state_q   <= S_DRAW;
                        end
                    end
                    S_DRAW: begin
                        if (pix_d != PEN_TRANSPARENT) begin
                            lb_we_n_q <= 1'b0;
                            lb_addr_q <= LB_AW'(x_q) + LB_AW'(col_q);
                            lb_data_q <= {color_q, pix_d};
                        end
                        if (col_q == 4'(SPR_H - 1)) begin
                            state_q <= S_NEXT;
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end
                    default: begin
                        if (idx_q == '0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q      <= idx_dec_d;
                            byte_q     <= BYTE_Y;
                            spr_addr_q <= {idx_dec_d, BYTE_Y};
                            state_q    <= S_ADDR;
                        end
                    end
                endcase
            end
        end
    end

    assign spr_addr  = spr_addr_q;
    assign gfx_req   = gfx_req_q;
    assign gfx_addr  = gfx_addr_q;
    assign lb_bank   = lb_bank_q;
    assign lb_addr   = lb_addr_q;
    assign lb_data   = lb_data_q;
    assign lb_we_n   = lb_we_n_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_exer_sprite_line_render.sv
// Bench for the sprite line renderer: sprite RAM and gfx ROM models, a
// reference line model feeding expected-write queues, and directed scenarios.
module tb_exer_sprite_line_render;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  target_line = 8'd0;
    logic [6:0]  spr_addr;
    logic [7:0]  spr_data;
    logic        gfx_req;
    logic [11:0] gfx_addr;
    logic        gfx_ack = 1'b0;
    logic [31:0] gfx_data = 32'd0;
    logic        lb_bank;
    logic [8:0]  lb_addr;
    logic [3:0]  lb_data;
    logic        lb_we_n;
    logic        busy;
    logic        overrun;
    logic [2:0]  dbg_state;

    exer_sprite_line_render dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start),
        .target_line(target_line), .spr_addr(spr_addr), .spr_data(spr_data),
        .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack),
        .gfx_data(gfx_data), .lb_bank(lb_bank), .lb_addr(lb_addr),
        .lb_data(lb_data), .lb_we_n(lb_we_n), .busy(busy),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [7:0]  sram [128];
    logic [31:0] gfx_word = 32'd0;
    int          gfx_lat = 2;
    always @(posedge clk) spr_data <= sram[spr_addr];

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: {lb_addr, lb_data} writes and gfx row addresses.
    logic [12:0] exp_q[$];
    logic [11:0] gfx_exp_q[$];
    logic        sb_en = 1'b0;
    logic        exp_bank = 1'b0;
    logic        req_prev = 1'b0;
    int          req_rises = 0;
    int          ovr_cnt = 0;
    logic [11:0] last_gaddr = 12'd0;
    logic [8:0]  max_addr = 9'd0;
    logic [3:0]  last_wr [512];

    initial begin
        logic [12:0] e;
        logic [11:0] g;
        forever begin
            @(negedge clk);
            if (reset_n && sb_en) begin
                if (!lb_we_n) begin
                    if (exp_q.size() == 0) begin
                        check_eq("lb_extra_write", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("lb_write", 32'({lb_addr, lb_data}), 32'(e));
                    end
                    last_wr[lb_addr] = lb_data;
                    if (lb_addr > max_addr) max_addr = lb_addr;
                end
                if (gfx_req && !req_prev) begin
                    req_rises++;
                    last_gaddr = gfx_addr;
                    if (gfx_exp_q.size() == 0) begin
                        check_eq("gfx_extra_req", 32'(gfx_exp_q.size()), 32'd1);
                    end else begin
                        g = gfx_exp_q.pop_front();
                        check_eq("gfx_addr", 32'(gfx_addr), 32'(g));
                    end
                end
                if (overrun) ovr_cnt++;
            end
            req_prev = gfx_req;
        end
    end

    // Gfx ROM: acks after gfx_lat cycles of continuous request.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (gfx_req) begin
                cnt++;
                if (cnt >= gfx_lat) begin
                    gfx_data = gfx_word;
                    gfx_ack  = 1'b1;
                    @(negedge clk);
                    gfx_ack  = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_spr();
        for (int i = 0; i < 128; i++) sram[i] = 8'd0;
    endtask

    task automatic set_spr(input int idx, input logic [7:0] y, code, attr, x);
        sram[idx*4 + 0] = y;
        sram[idx*4 + 1] = code;
        sram[idx*4 + 2] = attr;
        sram[idx*4 + 3] = x;
    endtask

    task automatic model_line(input logic [7:0] tl);
        logic [7:0] y, code, attr, x, dy;
        logic [3:0] row;
        logic [1:0] pix;
        logic [8:0] a;
        int col;
        for (int s = 31; s >= 0; s--) begin
            y = sram[s*4]; code = sram[s*4+1]; attr = sram[s*4+2]; x = sram[s*4+3];
            dy = tl - y;
            if (y == 8'd0 || dy >= 8'd16) continue;
            row = attr[7] ? (4'd15 - dy[3:0]) : dy[3:0];
            gfx_exp_q.push_back({code, row});
            for (int i = 0; i < 16; i++) begin
                col = attr[6] ? 15 - i : i;
                pix = gfx_word[2*col +: 2];
                a   = {1'b0, x} + 9'(i);
                if (pix != 2'b00) exp_q.push_back({a, attr[1:0], pix});
            end
        end
    endtask

    task automatic start_line(input logic [7:0] tl);
        @(negedge clk);
        target_line = tl;
        line_start  = 1'b1;
        exp_bank    = ~exp_bank;
        @(negedge clk);
        line_start  = 1'b0;
        check_eq("lb_bank", 32'(lb_bank), 32'(exp_bank));
        check_eq("busy_set", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check_eq("idle_timeout", 32'(busy), 32'd0);
        check_eq("lb_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("gfx_queue_empty", 32'(gfx_exp_q.size()), 32'd0);
        check_eq("req_low_idle", 32'(gfx_req), 32'd0);
    endtask

    task automatic run_line(input logic [7:0] tl);
        model_line(tl);
        start_line(tl);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_spr_addr"}, 32'(spr_addr), 32'd0);
        check_eq({tag, "_gfx_req"},  32'(gfx_req),  32'd0);
        check_eq({tag, "_gfx_addr"}, 32'(gfx_addr), 32'd0);
        check_eq({tag, "_lb_bank"},  32'(lb_bank),  32'd0);
        check_eq({tag, "_lb_addr"},  32'(lb_addr),  32'd0);
        check_eq({tag, "_lb_data"},  32'(lb_data),  32'd0);
        check_eq({tag, "_lb_we_n"},  32'(lb_we_n),  32'd1);
        check_eq({tag, "_busy"},     32'(busy),     32'd0);
        check_eq({tag, "_overrun"},  32'(overrun),  32'd0);
        check_eq({tag, "_state"},    32'(dbg_state), 32'd0);
    endtask

    initial begin
        int k;
        int rises0;
        clear_spr();
        for (int i = 0; i < 512; i++) last_wr[i] = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        sb_en   = 1'b1;

        // Plain sprite, some transparent columns.
        set_spr(5, 8'h40, 8'h12, 8'h01, 8'h20);
        gfx_word = 32'hE4E4_00E4;
        gfx_lat  = 3;
        run_line(8'h43);
        check_eq("t1_gfx_addr", 32'(last_gaddr), 32'h123);

        // Both flips: row 12, leftmost write takes the rightmost gfx pixel.
        set_spr(5, 8'h40, 8'h12, 8'hC1, 8'h20);
        gfx_word = 32'h9E37_79B9;
        run_line(8'h43);
        check_eq("t2_gfx_addr", 32'(last_gaddr), 32'h12C);
        check_eq("t2_first_px", 32'(last_wr[9'h20]), 32'h6);

        // Overlap: sprite 0 is drawn after sprite 3 and wins.
        clear_spr();
        set_spr(3, 8'h60, 8'h21, 8'h02, 8'h50);
        set_spr(0, 8'h60, 8'h22, 8'h03, 8'h50);
        gfx_word = 32'hFFFF_FFFF;
        run_line(8'h65);
        check_eq("t3_overlap", 32'(last_wr[9'h50]), 32'hF);

        // Y wrap draws row 10; dy of exactly 16 is skipped.
        clear_spr();
        set_spr(7, 8'hF8, 8'h33, 8'h00, 8'h10);
        gfx_word = 32'h5A5A_A5A5;
        gfx_lat  = $urandom_range(1, 6);
        run_line(8'h02);
        check_eq("t4_wrap_addr", 32'(last_gaddr), 32'h33A);
        clear_spr();
        set_spr(7, 8'h40, 8'h33, 8'h00, 8'h10);
        rises0 = req_rises;
        run_line(8'h50);
        check_eq("t4_skip_noreq", 32'(req_rises - rises0), 32'd0);

        // Right edge: addresses run past 0xFF without wrapping.
        clear_spr();
        set_spr(2, 8'h10, 8'h44, 8'h01, 8'hFA);
        gfx_word = 32'h5555_5555;
        max_addr = 9'd0;
        last_wr[0] = 4'd0;
        run_line(8'h10);
        check_eq("t5_max_addr", 32'(max_addr), 32'h109);
        check_eq("t5_no_wrap", 32'(last_wr[0]), 32'd0);

        // Overrun: gfx ack held off, new line arrives during the wait.
        clear_spr();
        set_spr(31, 8'h20, 8'h55, 8'h00, 8'h30);
        gfx_lat = 40;
        sb_en   = 1'b0;
        start_line(8'h20);
        k = 0;
        while (!gfx_req && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("t6_req_seen", 32'(gfx_req), 32'd1);
        repeat (10) @(negedge clk);
        ovr_cnt = 0;
        model_line(8'h20);
        sb_en = 1'b1;
        start_line(8'h20);
        gfx_lat = 2;
        check_eq("t6_overrun", 32'(overrun), 32'd1);
        check_eq("t6_req_drop", 32'(gfx_req), 32'd0);
        check_eq("t6_restart", 32'(spr_addr), 32'h7C);
        wait_idle();
        check_eq("t6_ovr_once", 32'(ovr_cnt), 32'd1);

        // Reset in the middle of DRAW.
        clear_spr();
        set_spr(4, 8'h30, 8'h66, 8'h01, 8'h70);
        gfx_word = 32'h5555_5555;
        sb_en = 1'b0;
        start_line(8'h35);
        k = 0;
        while (lb_we_n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_eq("t7_in_draw", 32'(lb_we_n), 32'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        exp_bank = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        gfx_exp_q.delete();
        sb_en = 1'b1;
        run_line(8'h35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
